// File: rtl/memwrite_monitor.sv
// Data-bus self-check monitor: matches core writes against an ordered table of
// expected (address, data) pairs. Define MONITOR_CYCLE_CNT_EN to add the RUN-cycle counter output.
module memwrite_monitor #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_EXP  = 8,
    parameter int IGN_BASE = 96,
    parameter int IGN_SIZE = 4,
    parameter int TIMEOUT  = 1000,
    localparam int IDX_W   = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_adr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    exp_count,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [IDX_W:0]    match_cnt
`ifdef MONITOR_CYCLE_CNT_EN
    , output logic [31:0]     cycles
`endif
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic TOUT_EN = (TIMEOUT > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    // Window bounds carry one extra bit so IGN_BASE+IGN_SIZE cannot wrap.
    localparam logic [ADDR_W:0] IGN_LO = (ADDR_W + 1)'(IGN_BASE);
    localparam logic [ADDR_W:0] IGN_HI = IGN_LO + (ADDR_W + 1)'(IGN_SIZE);
    localparam logic [IDX_W:0] NUM_EXP_V = (IDX_W + 1)'(NUM_EXP);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TOUT = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] tbl_adr  [NUM_EXP];
    logic [DATA_W-1:0] tbl_data [NUM_EXP];
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W:0]    n;
    logic [TMR_W-1:0]  timer;

    logic              in_window;
    logic              hit;
    logic              last;
    logic              timer_exp;
    logic              cfg_ok;
    logic [IDX_W:0]    ptr_next;
    logic [IDX_W:0]    n_start;

    // Write classification, pointer arithmetic and start-time length clamp.
    always_comb begin
        in_window = ({1'b0, Adr} >= IGN_LO) && ({1'b0, Adr} < IGN_HI);
        hit       = (Adr == tbl_adr[ptr]) && (WriteData == tbl_data[ptr]);
        ptr_next  = {1'b0, ptr} + (IDX_W + 1)'(1'b1);
        last      = (ptr_next == n);
        timer_exp = TOUT_EN && (timer == TMR_LAST);
        cfg_ok    = ({1'b0, cfg_idx} < NUM_EXP_V);
        if (exp_count > NUM_EXP_V) begin
            n_start = NUM_EXP_V;
        end else begin
            n_start = exp_count;
        end
    end

    // Expected table: deliberately not reset, frozen while a check is running.
    always_ff @(posedge clk) begin
        if (cfg_we && cfg_ok && (state != RUN)) begin
            tbl_adr[cfg_idx]  <= cfg_adr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    // Monitor FSM with registered verdict and failure-capture outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            n         <= '0;
            timer     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_adr  <= '0;
            fail_data <= '0;
            fail_idx  <= '0;
            match_cnt <= '0;
        end else if (start) begin
            ptr       <= '0;
            n         <= n_start;
            timer     <= '0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_adr  <= '0;
            fail_data <= '0;
            fail_idx  <= '0;
            match_cnt <= '0;
            if (n_start == '0) begin
                state <= PASS;
                pass  <= 1'b1;
                done  <= 1'b1;
            end else begin
                state <= RUN;
                pass  <= 1'b0;
                done  <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (MemWrite && !in_window && !hit) begin
                        state     <= FAIL;
                        fail      <= 1'b1;
                        done      <= 1'b1;
                        fail_adr  <= Adr;
                        fail_data <= WriteData;
                        fail_idx  <= ptr;
                    end else if (MemWrite && !in_window) begin
                        match_cnt <= match_cnt + (IDX_W + 1)'(1'b1);
                        if (last) begin
                            state <= PASS;
                            pass  <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            // ptr stops at n-1, so it only advances on non-final matches.
                            ptr <= ptr_next[IDX_W-1:0];
                            if (timer_exp) begin
                                state   <= TOUT;
                                timeout <= 1'b1;
                                done    <= 1'b1;
                            end else begin
                                timer <= timer + TMR_W'(1'b1);
                            end
                        end
                    end else if (timer_exp) begin
                        state   <= TOUT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1'b1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

`ifdef MONITOR_CYCLE_CNT_EN
    // RUN-cycle counter; holds its value once a verdict is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= 32'd0;
        end else if (start) begin
            cycles <= 32'd0;
        end else if (state == RUN) begin
            cycles <= cycles + 32'd1;
        end else begin
            cycles <= cycles;
        end
    end
`endif

endmodule

// File: tb/tb_memwrite_monitor.sv
// Bench for memwrite_monitor: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level reference model.
module tb_memwrite_monitor;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = 3'd0;
    logic [31:0] cfg_adr = 32'd0;
    logic [31:0] cfg_data = 32'd0;
    logic [3:0]  exp_count = 4'd0;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_adr, fail_data;
    logic [2:0]  fail_idx;
    logic [3:0]  match_cnt;
`ifdef MONITOR_CYCLE_CNT_EN
    logic [31:0] cycles;
`endif

    int total = 0;
    int bad = 0;

    // reference model: phase 0 idle, 1 run, 2 pass, 3 fail, 4 timeout
    int          m_phase, m_n, m_pos, m_age, m_fidx;
    logic [31:0] m_fadr, m_fdat;
    logic [31:0] m_tadr [8];
    logic [31:0] m_tdat [8];

    memwrite_monitor #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite),
        .Adr(Adr), .WriteData(WriteData), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_adr(cfg_adr), .cfg_data(cfg_data), .exp_count(exp_count),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_adr(fail_adr), .fail_data(fail_data), .fail_idx(fail_idx),
        .match_cnt(match_cnt)
`ifdef MONITOR_CYCLE_CNT_EN
        , .cycles(cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_age = 0; m_n = 0;
        m_fadr = 32'd0; m_fdat = 32'd0; m_fidx = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (cfg_we && m_phase != 1) begin
                m_tadr[cfg_idx] = cfg_adr;
                m_tdat[cfg_idx] = cfg_data;
            end
            if (start) begin
                m_n = (exp_count > 4'd8) ? 8 : int'(exp_count);
                m_pos = 0; m_age = 0;
                m_fadr = 32'd0; m_fdat = 32'd0; m_fidx = 0;
                m_phase = (m_n == 0) ? 2 : 1;
            end else if (m_phase == 1) begin
                m_age++;
                if (MemWrite && !(Adr >= 32'd96 && Adr < 32'd100)) begin
                    if (Adr == m_tadr[m_pos] && WriteData == m_tdat[m_pos]) begin
                        m_pos++;
                        if (m_pos == m_n) m_phase = 2;
                    end else begin
                        m_phase = 3;
                        m_fadr = Adr; m_fdat = WriteData; m_fidx = m_pos;
                    end
                end
                if (m_phase == 1 && m_age == TMO) m_phase = 4;
            end
        end
    endtask

    task automatic compare_all();
        check("done", done, m_phase >= 2);
        check("pass", pass, m_phase == 2);
        check("fail", fail, m_phase == 3);
        check("timeout", timeout, m_phase == 4);
        check("fail_adr", fail_adr, m_fadr);
        check("fail_data", fail_data, m_fdat);
        check("fail_idx", fail_idx, m_fidx);
        check("match_cnt", match_cnt, m_pos);
`ifdef MONITOR_CYCLE_CNT_EN
        check("cycles", cycles, m_age);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; Adr = a; WriteData = d;
        step();
        MemWrite = 1'b0;
    endtask

    task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_adr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input logic [3:0] cnt);
        exp_count = cnt; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 8; i++) begin m_tadr[i] = 32'd0; m_tdat[i] = 32'd0; end
        model_reset();
        step();
        check("rst_done", done, 1'b0);
        check("rst_match_cnt", match_cnt, 4'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) prog(i, 32'd0, 32'd0);

        // 1: ignored window write, then the single expected write
        prog(0, 32'd100, 32'd7);
        arm(4'd1);
        wr(32'd96, 32'd55);
        check("t1_not_yet", done, 1'b0);
        wr(32'd100, 32'd7);
        check("t1_pass", pass, 1'b1);
        check("t1_done", done, 1'b1);
        check("t1_fail", fail, 1'b0);

        // 2: wrong data
        arm(4'd1);
        wr(32'd100, 32'd8);
        check("t2_fail", fail, 1'b1);
        check("t2_fail_adr", fail_adr, 32'd100);
        check("t2_fail_data", fail_data, 32'd8);
        check("t2_fail_idx", fail_idx, 3'd0);
        check("t2_pass", pass, 1'b0);

        // 3: out-of-order write after one match
        prog(0, 32'd4, 32'd1); prog(1, 32'd8, 32'd2); prog(2, 32'd12, 32'd3);
        arm(4'd3);
        wr(32'd4, 32'd1);
        wr(32'd12, 32'd3);
        check("t3_fail", fail, 1'b1);
        check("t3_fail_idx", fail_idx, 3'd1);
        check("t3_match_cnt", match_cnt, 4'd1);

        // 4: timeout exactly TMO cycles after start; later writes ignored
        prog(0, 32'd100, 32'd7);
        arm(4'd1);
        idle(TMO - 1);
        check("t4_early", timeout, 1'b0);
        idle(1);
        check("t4_timeout", timeout, 1'b1);
        wr(32'd100, 32'd7);
        check("t4_sticky_pass", pass, 1'b0);
        check("t4_sticky_tout", timeout, 1'b1);

        // 5: final match in the expiry cycle wins
        arm(4'd1);
        idle(TMO - 1);
        wr(32'd100, 32'd7);
        check("t5_pass", pass, 1'b1);
        check("t5_timeout", timeout, 1'b0);

        // 6: asynchronous reset mid-run, then restart
        prog(0, 32'd4, 32'd1); prog(1, 32'd8, 32'd2); prog(2, 32'd12, 32'd3);
        arm(4'd3);
        wr(32'd4, 32'd1);
        idle(2);
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        check("t6_rst_match_cnt", match_cnt, 4'd0);
        step();
        reset = 1'b0;
        arm(4'd3);
        check("t6_restart_cnt", match_cnt, 4'd0);
        wr(32'd4, 32'd1);
        check("t6_one_match", match_cnt, 4'd1);

        // zero-length table passes straight away
        arm(4'd0);
        check("n0_pass", pass, 1'b1);

        // random traffic against the model
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 8; i++)
                prog(i, 32'd92 + 32'd4 * 32'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
            arm(4'($urandom_range(0, 15)));
            for (int c = 0; c < 25; c++) begin
                k = $urandom_range(0, 9);
                if (k <= 4) begin
                    MemWrite = 1'b1;
                    if (m_phase == 1 && m_pos < m_n) begin
                        Adr = m_tadr[m_pos]; WriteData = m_tdat[m_pos];
                    end else begin
                        Adr = 32'd100; WriteData = 32'($urandom_range(0, 3));
                    end
                end else if (k == 5) begin
                    MemWrite = 1'b1; Adr = 32'd96 + 32'($urandom_range(0, 3)); WriteData = $urandom;
                end else if (k == 6) begin
                    MemWrite = 1'b1; Adr = 32'd92 + 32'd4 * 32'($urandom_range(0, 7));
                    WriteData = 32'($urandom_range(0, 3));
                end else if (k == 7) begin
                    cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, 7));
                    cfg_adr = $urandom; cfg_data = $urandom;
                end else if (k == 9 && $urandom_range(0, 3) == 0) begin
                    start = 1'b1; exp_count = 4'($urandom_range(0, 15));
                end
                step();
                MemWrite = 1'b0; cfg_we = 1'b0; start = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
